// File: rtl/cali_apply_if.sv
// Bus bundle for cali_apply: calibration RAM read port, sample input stream,
// corrected sample output stream and the saturation counter.
interface cali_apply_if #(
    parameter int CH_W   = 8,
    parameter int DATA_W = 16
);
    logic [CH_W:0]       cali_address;
    logic                cali_chipselect;
    logic                cali_clken;
    logic                cali_write;
    logic [DATA_W-1:0]   cali_writedata;
    logic [1:0]          cali_byteenable;
    logic [DATA_W-1:0]   cali_readdata;

    logic                in_valid;
    logic                in_ready;
    logic [CH_W-1:0]     in_channel;
    logic [DATA_W-1:0]   in_data;
    logic                cfg_bypass;

    logic                out_valid;
    logic                out_ready;
    logic [CH_W-1:0]     out_channel;
    logic [DATA_W-1:0]   out_data;
    logic                out_sat;
    logic [15:0]         sat_count;

    modport master (
        output cali_address, cali_chipselect, cali_clken, cali_write,
               cali_writedata, cali_byteenable,
        input  cali_readdata,
        input  in_valid, in_channel, in_data, cfg_bypass,
        output in_ready,
        output out_valid, out_channel, out_data, out_sat, sat_count,
        input  out_ready
    );

    modport slave (
        input  cali_address, cali_chipselect, cali_clken, cali_write,
               cali_writedata, cali_byteenable,
        output cali_readdata,
        output in_valid, in_channel, in_data, cfg_bypass,
        input  in_ready,
        input  out_valid, out_channel, out_data, out_sat, sat_count,
        output out_ready
    );
endinterface

// File: rtl/cali_apply.sv
// Calibration-table reader and sample corrector. Each accepted sample fetches
// its channel's offset (word 2*ch) and Q2.14 gain (word 2*ch+1) from the
// calibration RAM, computes (raw - offset) * gain with a floor shift, clips to
// the signed sample range and presents the result with ready/valid.
module cali_apply #(
    parameter int CH_W      = 8,
    parameter int DATA_W    = 16,
    parameter int GAIN_FRAC = 14
) (
    input  logic          clk_clk,
    input  logic          reset_reset_n,
    cali_apply_if.master  bus
);

    localparam int PROD_W = 2 * (DATA_W + 1);
    localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'({1'b0, {(DATA_W-1){1'b1}}});
    localparam logic signed [PROD_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [2:0] {
        IDLE,
        RD_OFS,
        RD_GAIN,
        WAIT_GAIN,
        CALC,
        OUT
    } state_t;

    state_t state;
    state_t next_state;

    logic                in_ready_q;
    logic                accept;
    logic                ram_sel;
    logic [CH_W:0]       ram_addr;
    logic                out_valid_c;

    logic [CH_W-1:0]     ch_q;
    logic [DATA_W-1:0]   data_q;
    logic [DATA_W-1:0]   ofs_q;
    logic [DATA_W-1:0]   gain_q;

    logic [CH_W-1:0]     out_channel_q;
    logic [DATA_W-1:0]   out_data_q;
    logic                out_sat_q;
    logic [15:0]         sat_count_q;

    logic signed [DATA_W:0]   diff;
    logic signed [PROD_W-1:0] diff_x;
    logic signed [PROD_W-1:0] gain_x;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] res;
    logic                     sat_hi;
    logic                     sat_lo;
    logic [DATA_W-1:0]        clipped;

    assign accept = (state == IDLE) && in_ready_q && bus.in_valid;

    // Correction arithmetic: 17-bit difference, signed product, floor shift, clip
    assign diff    = $signed({data_q[DATA_W-1], data_q}) - $signed({ofs_q[DATA_W-1], ofs_q});
    assign diff_x  = PROD_W'(diff);
    assign gain_x  = PROD_W'({1'b0, gain_q});
    assign prod    = diff_x * gain_x;
    assign res     = prod >>> GAIN_FRAC;
    assign sat_hi  = res > SAT_MAX;
    assign sat_lo  = res < SAT_MIN;
    assign clipped = sat_hi ? SAT_MAX[DATA_W-1:0] :
                     sat_lo ? SAT_MIN[DATA_W-1:0] : res[DATA_W-1:0];

    // State register; reset drops any in-flight sample immediately
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and RAM port / output-valid decode from the current state
    always_comb begin
        next_state  = state;
        ram_sel     = 1'b0;
        ram_addr    = '0;
        out_valid_c = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = bus.cfg_bypass ? OUT : RD_OFS;
                end
            end
            RD_OFS: begin
                ram_sel    = 1'b1;
                ram_addr   = {ch_q, 1'b0};
                next_state = RD_GAIN;
            end
            RD_GAIN: begin
                ram_sel    = 1'b1;
                ram_addr   = {ch_q, 1'b1};
                next_state = WAIT_GAIN;
            end
            WAIT_GAIN: begin
                next_state = CALC;
            end
            CALC: begin
                next_state = OUT;
            end
            OUT: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // in_ready is registered so it stays low while reset is held and rises after release
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            in_ready_q <= 1'b0;
        end else begin
            in_ready_q <= (next_state == IDLE);
        end
    end

    // Sample capture, table words, registered results and saturation counter
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            ch_q          <= '0;
            data_q        <= '0;
            ofs_q         <= '0;
            gain_q        <= '0;
            out_channel_q <= '0;
            out_data_q    <= '0;
            out_sat_q     <= 1'b0;
            sat_count_q   <= '0;
        end else begin
            if (accept) begin
                ch_q   <= bus.in_channel;
                data_q <= bus.in_data;
                if (bus.cfg_bypass) begin
                    out_channel_q <= bus.in_channel;
                    out_data_q    <= bus.in_data;
                    out_sat_q     <= 1'b0;
                end
            end
            if (state == RD_GAIN) begin
                ofs_q <= bus.cali_readdata;
            end
            if (state == WAIT_GAIN) begin
                gain_q <= bus.cali_readdata;
            end
            if (state == CALC) begin
                out_channel_q <= ch_q;
                out_data_q    <= clipped;
                out_sat_q     <= sat_hi | sat_lo;
                if ((sat_hi | sat_lo) && (sat_count_q != 16'hFFFF)) begin
                    sat_count_q <= sat_count_q + 16'd1;
                end
            end
        end
    end

    assign bus.cali_address    = ram_addr;
    assign bus.cali_chipselect = ram_sel;
    assign bus.cali_clken      = ram_sel;
    assign bus.cali_write      = 1'b0;
    assign bus.cali_writedata  = '0;
    assign bus.cali_byteenable = 2'b11;
    assign bus.in_ready        = in_ready_q;
    assign bus.out_valid       = out_valid_c;
    assign bus.out_channel     = out_channel_q;
    assign bus.out_data        = out_data_q;
    assign bus.out_sat         = out_sat_q;
    assign bus.sat_count       = sat_count_q;

endmodule

// File: doc/cali_apply.md
# cali_apply

Calibration-table reader and sample corrector for the fibre BPM DAQ. It sits between the per-channel ADC sample stream and the downstream processing and acts as the read-only master on the second port of the 512×16 dual-ported calibration RAM. For each incoming sample it fetches that channel's offset and gain words, applies the correction, and emits the corrected sample with ready/valid flow control.

## Interface
Parameters:
- CH_W, 8, channel index width; RAM address width is CH_W+1
- DATA_W, 16, sample and RAM word width
- GAIN_FRAC, 14, gain fractional bits (unsigned Q2.14, 0x4000 = 1.0)

Ports:
- clk_clk  in  1  single clock for the whole block
- reset_reset_n  in  1  asynchronous, active-low reset
- cali_address  out  CH_W+1  RAM word address
- cali_chipselect  out  1  RAM select
- cali_clken  out  1  RAM clock enable
- cali_write  out  1  tied 0
- cali_writedata  out  DATA_W  tied 0
- cali_byteenable  out  2  tied 2'b11
- cali_readdata  in  DATA_W  RAM read data, valid one cycle after the address
- in_valid / in_ready  in / out  1  input handshake
- in_channel  in  CH_W  channel index
- in_data  in  DATA_W  raw sample, signed
- cfg_bypass  in  1  pass raw samples through, sampled at accept
- out_valid / out_ready  out / in  1  output handshake
- out_channel  out  CH_W  channel of the output sample
- out_data  out  DATA_W  corrected sample, signed
- out_sat  out  1  output sample was saturated
- sat_count  out  16  number of saturated samples, sticky at 0xFFFF

## Operation
- Table layout: word 2·ch holds the signed offset for channel ch; word 2·ch+1 holds the unsigned Q2.14 gain.
- FSM states: IDLE, RD_OFS, RD_GAIN, WAIT_GAIN, CALC, OUT.
- IDLE: in_ready=1. A sample is accepted on in_valid&in_ready, and in_channel, in_data and cfg_bypass are latched. Next state is RD_OFS, or OUT if bypass was latched.
- RD_OFS: cali_address={ch,0}, chipselect=1, clken=1. Next state RD_GAIN.
- RD_GAIN: cali_address={ch,1}, chipselect=1, clken=1. cali_readdata is latched as the offset. Next state WAIT_GAIN.
- WAIT_GAIN: chipselect=0. cali_readdata is latched as the gain. Next state CALC.
- CALC:
  - diff = in_data − offset, 17-bit signed.
  - prod = diff × {0,gain}, 34-bit signed.
  - res = prod >>> GAIN_FRAC, arithmetic shift, so the result rounds toward −∞.
  - res is saturated to [−32768, 32767]. out_sat is set if clipping occurred, and sat_count is incremented (saturating).
  - All results are registered. Next state OUT.
- OUT: out_valid=1 with out_channel, out_data and out_sat held stable until out_ready=1. After that handshake, next state is IDLE.
- Bypass: out_data=in_data, out_sat=0, no RAM access.
- cali_chipselect and cali_clken are 0 outside RD_OFS and RD_GAIN. cali_write is always 0.
- Reset values: state IDLE; in_ready=0 while reset is asserted and 1 after release; every other output 0; cali_byteenable=2'b11.
- Reset mid-operation: all state clears immediately, the in-flight sample is discarded, and chipselect drops asynchronously. sat_count clears only on reset.

## Timing
- Accept at edge T. RD_OFS runs in cycle T+1, RD_GAIN in T+2, WAIT_GAIN in T+3, CALC in T+4, and out_valid rises at T+5.
- Bypass: out_valid rises at T+1.
- With out_ready held high, the block returns to IDLE at T+6. Throughput is therefore one sample per 6 cycles, or one per 2 cycles in bypass.
- in_ready=0 in every state except IDLE; there is no input buffering.
- out_valid does not depend combinationally on out_ready. Outputs are registered.
- A RAM-port-1 write to the same word in the same cycle as the read returns old data. The block tolerates this; table updates are software's responsibility.

## Test plan
- Basic correction: load table[6]=100 and table[7]=0x4000. Send ch=3, raw=1100. Expect cali_address=6 at T+1 and 7 at T+2, out_data=1000 at T+5, out_sat=0.
- Saturation: offset=−20000 (0xB1E0), gain=0x8000, raw=20000. Expect out_data=32767, out_sat=1, sat_count=1. Repeat with raw=−20000 and offset=20000: expect −32768 and sat_count=2.
- Rounding: offset=0, gain=0x2000. raw=−10 gives −5; raw=−3 gives −2; raw=3 gives 1.
- Backpressure: hold out_ready=0 for 10 cycles. out_valid and out_data stay stable, in_ready=0, chipselect=0. Release, and the next accept occurs exactly one cycle after the output handshake.
- Bypass: cfg_bypass=1, raw=−1234, ch=255. Expect no chipselect pulse and out_data=−1234 at T+1.
- Reset: assert reset_reset_n=0 during RD_GAIN. Chipselect and out_valid go to 0 immediately and sat_count=0. After release in_ready=1, and the next sample is processed normally.
